byte_transpose_stream: RTL and testbench
========================================

BYTE_TRANSPOSE_STREAM -- requirements
Module: byte_transpose_stream

Interface
REQ-001 The block SHALL have parameter NUM_ROWS, default 4, meaning rows of the byte matrix.
REQ-002 The block SHALL have parameter NUM_COLS, default 4, meaning columns of the byte matrix.
REQ-003 The block SHALL have parameter BYTE_W, default 8, meaning bits per lane.
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning width of the block counter.
REQ-005 Derived: N = NUM_ROWS*NUM_COLS lanes; DATA_W = N*BYTE_W; defaults give 128 bits, 16 lanes.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-008 The block SHALL have port in_valid, input, 1, meaning the input word is offered.
REQ-009 The block SHALL have port in_ready, output, 1, meaning the block can accept a word this cycle.
REQ-010 The block SHALL have port in_data, input, DATA_W, meaning the input word; lane k = in_data[k*BYTE_W +: BYTE_W].
REQ-011 The block SHALL have port in_mode, input, 2, meaning the permutation select for this word.
REQ-012 The block SHALL have port out_valid, output, 1, meaning out_data holds a valid result.
REQ-013 The block SHALL have port out_ready, input, 1, meaning the consumer takes out_data this cycle.
REQ-014 The block SHALL have port out_data, output, DATA_W, meaning the permuted word.
REQ-015 The block SHALL have port blk_cnt, output, CNT_W, meaning the count of output handshakes completed.

Function
REQ-016 An input handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output handshake SHALL occur where out_valid=1 and out_ready=1.
REQ-017 The block SHALL permute lanes as follows: mode 2'b00 forward transpose, out lane k = in lane (k mod NUM_ROWS)*NUM_COLS + (k div NUM_ROWS).
REQ-018 Mode 2'b01 SHALL apply the inverse transpose: out lane k = in lane (k mod NUM_COLS)*NUM_ROWS + (k div NUM_COLS).
REQ-019 Modes 2'b10 and 2'b11 SHALL apply bypass: out lane k = in lane k.
REQ-020 With default parameters, mode 00 SHALL equal the SNOW-V sigma map {0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15}, and modes 00 and 01 SHALL give identical results.
REQ-021 in_mode SHALL be sampled only on an input handshake and SHALL apply only to that word.
REQ-022 Permuted words SHALL enter a 2-entry FIFO: write pointer, read pointer and occupancy count (0..2).
REQ-023 Latency: a word accepted on edge t SHALL be presented with out_valid=1 in the cycle after edge t, provided the FIFO was empty.
REQ-024 in_ready SHALL be a registered signal equal to (occupancy < 2), with no combinational path from out_ready.
REQ-025 out_valid SHALL be (occupancy != 0), and out_data SHALL be the FIFO head, registered with no combinational path from in_data.
REQ-026 A simultaneous input and output handshake SHALL leave occupancy unchanged and preserve word order.
REQ-027 While full, in_valid SHALL be ignored and no data SHALL be lost or overwritten.
REQ-028 While empty, out_ready SHALL be ignored and blk_cnt SHALL not change.
REQ-029 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 Sustained in_valid=1 and out_ready=1 SHALL give one word per cycle throughput.
REQ-031 blk_cnt SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-032 Pointers SHALL wrap modulo 2.

Reset
REQ-033 When rst=1 at a rising edge, occupancy, both pointers and blk_cnt SHALL become 0, out_valid SHALL become 0, and in_ready SHALL become 1 the cycle after rst deasserts.
REQ-034 in_ready SHALL be 0 while rst=1.
REQ-035 Reset mid-stream SHALL discard all buffered words, and handshakes in the reset cycle SHALL have no effect.
REQ-036 FIFO data storage SHALL not require reset; out_data SHALL be ignored while out_valid=0.

Verification
REQ-037 Defaults, mode 00, in_data=0x0f0e0d0c0b0a09080706050403020100, out_ready=1: next cycle out_data=0x0f0b07030e0a06020d0905010c080400, out_valid=1, blk_cnt=1.
REQ-038 Same word with mode 10: out_data equals in_data. Then mode 01: out_data=0x0f0b07030e0a06020d0905010c080400.
REQ-039 NUM_ROWS=2, NUM_COLS=8, lane k = k:
- mode 00 SHALL give lanes 0,8,1,9,2,10,...,7,15.
- mode 01 SHALL give lanes 0,2,4,...,14,1,3,...,15.
REQ-040 Backpressure: out_ready=0 and three words offered back-to-back -> the first two are accepted and in_ready=0 from the cycle after the second; after out_ready=1 the words emerge in order with none lost, and out_data is stable while stalled.
REQ-041 Reset: assert rst with 2 words buffered and blk_cnt=5 -> next cycle out_valid=0, blk_cnt=0, in_ready=0 until the cycle after rst deasserts.
REQ-042 Counter wrap: CNT_W=4 and 17 output handshakes -> blk_cnt=1.

Source files
------------

// File: rtl/byte_transpose_stream.sv
// Lane permutation (forward/inverse transpose or bypass) of a NUM_ROWS x NUM_COLS
// byte matrix, followed by a 2-entry output FIFO with a registered ready/valid interface.
module byte_transpose_stream #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    parameter int BYTE_W   = 8,
    parameter int CNT_W    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_ROWS*NUM_COLS*BYTE_W-1:0]  in_data,
    input  logic [1:0]                           in_mode,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_ROWS*NUM_COLS*BYTE_W-1:0]  out_data,
    output logic [CNT_W-1:0]                     blk_cnt
);

    localparam int N      = NUM_ROWS * NUM_COLS;
    localparam int DATA_W = N * BYTE_W;

    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] inv_data;
    logic [DATA_W-1:0] perm_data;

    logic [DATA_W-1:0] mem [0:1];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              in_ready_q;
    logic [CNT_W-1:0]  blk_cnt_q;
    logic              push;
    logic              pop;

    // Source lane indices are elaboration-time constants, so the permutation is pure wiring.
    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int FWD_SRC = (k % NUM_ROWS) * NUM_COLS + (k / NUM_ROWS);
        localparam int INV_SRC = (k % NUM_COLS) * NUM_ROWS + (k / NUM_COLS);
        assign fwd_data[k*BYTE_W +: BYTE_W] = in_data[FWD_SRC*BYTE_W +: BYTE_W];
        assign inv_data[k*BYTE_W +: BYTE_W] = in_data[INV_SRC*BYTE_W +: BYTE_W];
    end

    always_comb begin
        perm_data = in_data;
        case (in_mode)
            2'b00:   perm_data = fwd_data;
            2'b01:   perm_data = inv_data;
            default: perm_data = in_data;
        endcase
    end

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // in_ready is precomputed from the next occupancy so it never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_ready_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next != 2'd2);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                blk_cnt_q <= blk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= perm_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_byte_transpose_stream.sv
// Directed bench: a default 4x4 instance (A) and a 2x8 instance with a 4-bit block counter (B).
module tb_byte_transpose_stream;

    localparam logic [127:0] SEQ = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] T44 = 128'h0f0b07030e0a06020d0905010c080400;

    typedef struct {
        logic         sel;
        logic [1:0]   mode;
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]   a_in_mode;
    logic [127:0] a_in_data, a_out_data;
    logic [31:0]  a_blk_cnt;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]   b_in_mode;
    logic [127:0] b_in_data, b_out_data;
    logic [3:0]   b_blk_cnt;

    int checks = 0;
    int errors = 0;
    int exp_a  = 0;
    int exp_b  = 0;
    vec_t vecs [10];

    always #5 clk = ~clk;

    byte_transpose_stream u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .blk_cnt(a_blk_cnt)
    );

    byte_transpose_stream #(.NUM_ROWS(2), .NUM_COLS(8), .BYTE_W(8), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .blk_cnt(b_blk_cnt)
    );

    task automatic applyStimulus(input logic sel, input logic [1:0] mode,
                                 input logic [127:0] din, input logic valid);
        if (sel) begin
            b_in_valid = valid;
            b_in_mode  = mode;
            b_in_data  = din;
            a_in_valid = 1'b0;
        end else begin
            a_in_valid = valid;
            a_in_mode  = mode;
            a_in_data  = din;
            b_in_valid = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fill_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {16{b}};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 2'b00, SEQ, T44};
        vecs[1] = '{1'b0, 2'b10, SEQ, SEQ};
        vecs[2] = '{1'b0, 2'b01, SEQ, T44};
        vecs[3] = '{1'b0, 2'b11, SEQ, SEQ};
        vecs[4] = '{1'b0, 2'b00, 128'hffeeddccbbaa99887766554433221100, 128'hffbb7733eeaa6622dd995511cc884400};
        vecs[5] = '{1'b0, 2'b01, 128'h00112233445566778899aabbccddeeff, 128'h004488cc115599dd2266aaee3377bbff};
        vecs[6] = '{1'b1, 2'b00, SEQ, 128'h0f070e060d050c040b030a0209010800};
        vecs[7] = '{1'b1, 2'b01, SEQ, 128'h0f0d0b09070503010e0c0a0806040200};
        vecs[8] = '{1'b1, 2'b10, SEQ, SEQ};
        vecs[9] = '{1'b1, 2'b00, 128'hffeeddccbbaa99887766554433221100, 128'hff77ee66dd55cc44bb33aa2299118800};

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_mode = 2'b00; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 2'b00; b_in_data = '0; b_out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_a_in_ready", 128'(a_in_ready), 128'd0);
        checkOutput("rst_a_out_valid", 128'(a_out_valid), 128'd0);
        checkOutput("rst_a_blk_cnt", 128'(a_blk_cnt), 128'd0);
        checkOutput("rst_b_in_ready", 128'(b_in_ready), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_a_in_ready", 128'(a_in_ready), 128'd1);
        checkOutput("post_rst_b_in_ready", 128'(b_in_ready), 128'd1);
        checkOutput("post_rst_a_out_valid", 128'(a_out_valid), 128'd0);

        // Single-word vectors, one at a time, consumer always ready
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].sel, vecs[i].mode, vecs[i].din, 1'b1);
            @(negedge clk);
            applyStimulus(vecs[i].sel, 2'b11, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b0);
            if (vecs[i].sel) begin
                checkOutput($sformatf("vec%0d_valid", i), 128'(b_out_valid), 128'd1);
                checkOutput($sformatf("vec%0d_data", i), b_out_data, vecs[i].dexp);
            end else begin
                checkOutput($sformatf("vec%0d_valid", i), 128'(a_out_valid), 128'd1);
                checkOutput($sformatf("vec%0d_data", i), a_out_data, vecs[i].dexp);
            end
            @(negedge clk);
            if (vecs[i].sel) begin
                exp_b = (exp_b + 1) % 16;
                checkOutput($sformatf("vec%0d_blk_cnt", i), 128'(b_blk_cnt), 128'(exp_b));
                checkOutput($sformatf("vec%0d_drained", i), 128'(b_out_valid), 128'd0);
            end else begin
                exp_a = exp_a + 1;
                checkOutput($sformatf("vec%0d_blk_cnt", i), 128'(a_blk_cnt), 128'(exp_a));
                checkOutput($sformatf("vec%0d_drained", i), 128'(a_out_valid), 128'd0);
            end
        end

        // Throughput: five back-to-back bypass words on A
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkOutput($sformatf("tput%0d_valid", i), 128'(a_out_valid), 128'd1);
                checkOutput($sformatf("tput%0d_data", i), a_out_data, fill_word(i + 32));
                checkOutput($sformatf("tput%0d_in_ready", i), 128'(a_in_ready), 128'd1);
            end
            if (i < 5) applyStimulus(1'b0, 2'b10, fill_word(i + 33), 1'b1);
            else       applyStimulus(1'b0, 2'b10, '0, 1'b0);
        end
        @(negedge clk);
        exp_a = exp_a + 5;
        checkOutput("tput_blk_cnt", 128'(a_blk_cnt), 128'(exp_a));

        // Backpressure: three words offered while the consumer stalls
        a_out_ready = 1'b0;
        applyStimulus(1'b0, 2'b10, 128'h11111111222222223333333344444444, 1'b1);
        @(negedge clk);
        checkOutput("bp_in_ready_1", 128'(a_in_ready), 128'd1);
        checkOutput("bp_head_1", a_out_data, 128'h11111111222222223333333344444444);
        applyStimulus(1'b0, 2'b00, SEQ, 1'b1);
        @(negedge clk);
        checkOutput("bp_full_in_ready", 128'(a_in_ready), 128'd0);
        checkOutput("bp_head_2", a_out_data, 128'h11111111222222223333333344444444);
        applyStimulus(1'b0, 2'b11, 128'hcafef00dcafef00dcafef00dcafef00d, 1'b1);
        @(negedge clk);
        checkOutput("bp_still_full", 128'(a_in_ready), 128'd0);
        checkOutput("bp_stable", a_out_data, 128'h11111111222222223333333344444444);
        checkOutput("bp_valid", 128'(a_out_valid), 128'd1);
        a_out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_out_2", a_out_data, T44);
        checkOutput("bp_reopen", 128'(a_in_ready), 128'd1);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, '0, 1'b0);
        checkOutput("bp_out_3", a_out_data, 128'hcafef00dcafef00dcafef00dcafef00d);
        checkOutput("bp_out_3_valid", 128'(a_out_valid), 128'd1);
        @(negedge clk);
        exp_a = exp_a + 3;
        checkOutput("bp_drained", 128'(a_out_valid), 128'd0);
        checkOutput("bp_blk_cnt", 128'(a_blk_cnt), 128'(exp_a));

        // Mid-stream reset with two words buffered and handshakes offered during reset
        a_out_ready = 1'b0;
        applyStimulus(1'b0, 2'b10, fill_word(7), 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 2'b10, fill_word(8), 1'b1);
        @(negedge clk);
        checkOutput("mr_full", 128'(a_in_ready), 128'd0);
        rst = 1'b1;
        a_out_ready = 1'b1;
        applyStimulus(1'b0, 2'b10, fill_word(9), 1'b1);
        @(negedge clk);
        checkOutput("mr_out_valid", 128'(a_out_valid), 128'd0);
        checkOutput("mr_blk_cnt", 128'(a_blk_cnt), 128'd0);
        checkOutput("mr_in_ready", 128'(a_in_ready), 128'd0);
        @(negedge clk);
        checkOutput("mr_in_ready_hold", 128'(a_in_ready), 128'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 2'b10, '0, 1'b0);
        checkOutput("mr_in_ready_deassert", 128'(a_in_ready), 128'd0);
        @(negedge clk);
        checkOutput("mr_in_ready_back", 128'(a_in_ready), 128'd1);
        checkOutput("mr_discarded", 128'(a_out_valid), 128'd0);
        repeat (2) @(negedge clk);
        checkOutput("empty_blk_cnt_a", 128'(a_blk_cnt), 128'd0);
        checkOutput("empty_blk_cnt_b", 128'(b_blk_cnt), 128'd0);

        // Counter wrap on B: 17 output handshakes with a 4-bit counter
        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            if (i > 0) checkOutput($sformatf("wrap%0d_data", i), b_out_data, fill_word(i + 99));
            if (i < 17) applyStimulus(1'b1, 2'b10, fill_word(i + 100), 1'b1);
            else        applyStimulus(1'b1, 2'b10, '0, 1'b0);
        end
        @(negedge clk);
        checkOutput("wrap_blk_cnt", 128'(b_blk_cnt), 128'd1);
        checkOutput("wrap_drained", 128'(b_out_valid), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
